// File: rtl/vga_pkg.sv
// Screen constants and motion-control encodings shared by the sprite logic.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccel = 2'd1,
        StBrake = 2'd2
    } motion_state_e;

    typedef enum logic [1:0] {
        ReqNone  = 2'd0,
        ReqLeft  = 2'd1,
        ReqRight = 2'd2
    } motion_req_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer plus a frame-rate debounce counter.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_FRAMES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic tick,
    output logic level
);

    logic [1:0] sync_q, sync_d;
    logic [2:0] cnt_q, cnt_d;
    logic       level_q, level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        sync_d  = {sync_q[0], btn};
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick) begin
            if (sync_q[1] != level_q) begin
                if (cnt_q + 3'd1 == 3'(DEBOUNCE_FRAMES)) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-rate sprite motion: vsync edge detect, accel/brake FSM and clamped x position.
module sprite_motion_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned X_MIN            = 20,
    parameter int unsigned X_MAX            = 620,
    parameter int unsigned X_INIT           = 320,
    parameter int unsigned MAX_SPEED        = 4,
    parameter int unsigned DEBOUNCE_FRAMES  = 2,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       vsync,
    output logic [9:0] x_center,
    output logic [2:0] speed,
    output logic       dir,
    output logic       moving,
    output logic       hit_edge
);

    localparam logic [9:0]        XMin   = 10'(X_MIN);
    localparam logic [9:0]        XMax   = 10'(X_MAX);
    localparam logic signed [10:0] XMinS = 11'(X_MIN);
    localparam logic signed [10:0] XMaxS = 11'(X_MAX);
    localparam logic [2:0]        SpdMax = 3'(MAX_SPEED);

    logic [1:0]    vs_sync_q, vs_sync_d;
    logic          vs_prev_q, vs_prev_d;
    logic          frame_tick_q, frame_tick_d;
    logic          tick_q, tick_d;
    motion_state_e state_q, state_d;
    logic [2:0]    speed_q, speed_d;
    logic          dir_q, dir_d;
    logic [9:0]    x_q, x_d;
    logic          moving_q, moving_d;
    logic          hit_q, hit_d;

    logic          vs_act;
    logic          left_lvl, right_lvl;
    motion_req_e   req;
    logic signed [10:0] x_next;

    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_left (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_left),
        .tick  (frame_tick_q),
        .level (left_lvl)
    );

    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_right (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_right),
        .tick  (frame_tick_q),
        .level (right_lvl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_sync_q    <= '0;
            vs_prev_q    <= 1'b1;  // treat vsync as already asserted: needs a fresh edge
            frame_tick_q <= 1'b0;
            tick_q       <= 1'b0;
            state_q      <= StIdle;
            speed_q      <= '0;
            dir_q        <= 1'b1;
            x_q          <= 10'(X_INIT);
            moving_q     <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            vs_sync_q    <= vs_sync_d;
            vs_prev_q    <= vs_prev_d;
            frame_tick_q <= frame_tick_d;
            tick_q       <= tick_d;
            state_q      <= state_d;
            speed_q      <= speed_d;
            dir_q        <= dir_d;
            x_q          <= x_d;
            moving_q     <= moving_d;
            hit_q        <= hit_d;
        end
    end

    always_comb begin
        vs_sync_d    = {vs_sync_q[0], vsync};
        vs_act       = VSYNC_ACTIVE_LOW ? ~vs_sync_q[1] : vs_sync_q[1];
        vs_prev_d    = vs_act;
        frame_tick_d = vs_act & ~vs_prev_q;
        tick_d       = frame_tick_q;

        if (left_lvl == right_lvl) req = ReqNone;
        else if (left_lvl)         req = ReqLeft;
        else                       req = ReqRight;

        state_d = state_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        x_d     = x_q;
        hit_d   = 1'b0;
        x_next  = $signed({1'b0, x_q});

        if (tick_q) begin
            unique case (state_q)
                StIdle: begin
                    if (req == ReqRight && x_q != XMax) begin
                        state_d = StAccel;
                        dir_d   = 1'b1;
                        speed_d = 3'd1;
                    end else if (req == ReqLeft && x_q != XMin) begin
                        state_d = StAccel;
                        dir_d   = 1'b0;
                        speed_d = 3'd1;
                    end
                end
                StAccel: begin
                    if ((req == ReqRight && dir_q) || (req == ReqLeft && !dir_q)) begin
                        speed_d = (speed_q >= SpdMax) ? SpdMax : speed_q + 3'd1;
                    end else begin
                        speed_d = (speed_q == 3'd0) ? 3'd0 : speed_q - 3'd1;
                        state_d = (speed_d == 3'd0) ? StIdle : StBrake;
                    end
                end
                StBrake: begin
                    speed_d = (speed_q == 3'd0) ? 3'd0 : speed_q - 3'd1;
                    if (speed_d == 3'd0) state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    speed_d = '0;
                end
            endcase

            if (dir_d) x_next = $signed({1'b0, x_q}) + $signed({8'b0, speed_d});
            else       x_next = $signed({1'b0, x_q}) - $signed({8'b0, speed_d});

            if (x_next > XMaxS || x_next < XMinS) begin
                x_d     = (x_next > XMaxS) ? XMax : XMin;
                speed_d = '0;
                state_d = StIdle;
                hit_d   = 1'b1;
            end else begin
                x_d = x_next[9:0];
            end
        end

        moving_d = (state_d != StIdle);
    end

    assign x_center = x_q;
    assign speed    = speed_q;
    assign dir      = dir_q;
    assign moving   = moving_q;
    assign hit_edge = hit_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed self-checking bench for sprite_motion_ctrl at default parameters.
module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left, btn_right, vsync;
    logic [9:0] x_center;
    logic [2:0] speed;
    logic       dir, moving, hit_edge;

    int total = 0;
    int bad   = 0;
    int hit_cnt = 0;

    sprite_motion_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .vsync     (vsync),
        .x_center  (x_center),
        .speed     (speed),
        .dir       (dir),
        .moving    (moving),
        .hit_edge  (hit_edge)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (hit_edge) hit_cnt++;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One video frame: vsync high 3 clocks, low 7; returns #1 after a rising edge.
    task automatic frame();
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        hit_cnt = 0;
    endtask

    int spd_up[10] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4};
    int spd_dn[5]  = '{4, 3, 2, 1, 0};
    int x_dn[5]    = '{354, 357, 359, 360, 360};

    initial begin
        btn_left  = 1'b0;
        btn_right = 1'b0;
        vsync     = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_x", int'(x_center), 320);
        check_val("rst_speed", int'(speed), 0);
        check_val("rst_moving", int'(moving), 0);
        check_val("rst_hit", int'(hit_edge), 0);
        check_val("rst_dir", int'(dir), 1);
        reset = 1'b0;
        hit_cnt = 0;

        repeat (2) frame();
        check_val("idle_x", int'(x_center), 320);

        // Single-frame glitch must be rejected.
        btn_right = 1'b1;
        frame();
        btn_right = 1'b0;
        repeat (2) frame();
        check_val("glitch_x", int'(x_center), 320);
        check_val("glitch_speed", int'(speed), 0);

        // Both buttons cancel.
        btn_left  = 1'b1;
        btn_right = 1'b1;
        repeat (4) frame();
        check_val("both_x", int'(x_center), 320);
        check_val("both_moving", int'(moving), 0);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        repeat (3) frame();
        check_val("both_rel_x", int'(x_center), 320);

        // Accelerate right for ten ticks.
        btn_right = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frame();
            check_val($sformatf("acc_speed_t%0d", i + 1), int'(speed), spd_up[i]);
        end
        check_val("acc_x", int'(x_center), 350);
        check_val("acc_moving", int'(moving), 1);
        check_val("acc_dir", int'(dir), 1);

        // Release: one more tick at full speed, then brake to rest.
        btn_right = 1'b0;
        for (int i = 0; i < 5; i++) begin
            frame();
            check_val($sformatf("brk_speed_t%0d", i + 1), int'(speed), spd_dn[i]);
            check_val($sformatf("brk_x_t%0d", i + 1), int'(x_center), x_dn[i]);
        end
        check_val("brk_moving", int'(moving), 0);
        check_val("brk_hits", hit_cnt, 0);

        // Hold right from reset into the wall.
        do_reset();
        btn_right = 1'b1;
        repeat (77) frame();
        check_val("wall_pre_x", int'(x_center), 618);
        check_val("wall_pre_speed", int'(speed), 4);
        check_val("wall_pre_hits", hit_cnt, 0);
        frame();
        check_val("wall_x", int'(x_center), 620);
        check_val("wall_hits", hit_cnt, 1);
        check_val("wall_speed", int'(speed), 0);
        check_val("wall_moving", int'(moving), 0);
        check_val("wall_hit_low", int'(hit_edge), 0);
        repeat (5) frame();
        check_val("wall_hold_x", int'(x_center), 620);
        check_val("wall_hold_hits", hit_cnt, 1);
        check_val("wall_hold_moving", int'(moving), 0);

        // Leaving the wall to the left.
        btn_right = 1'b0;
        btn_left  = 1'b1;
        repeat (2) frame();
        check_val("left_x", int'(x_center), 619);
        check_val("left_dir", int'(dir), 0);
        check_val("left_speed", int'(speed), 1);
        btn_left = 1'b0;

        // Asynchronous reset mid-motion.
        do_reset();
        btn_right = 1'b1;
        repeat (6) frame();
        check_val("mid_speed", int'(speed), 4);
        check_val("mid_x", int'(x_center), 334);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_val("arst_x", int'(x_center), 320);
        check_val("arst_speed", int'(speed), 0);
        check_val("arst_moving", int'(moving), 0);
        check_val("arst_dir", int'(dir), 1);
        check_val("arst_hit", int'(hit_edge), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        frame();
        check_val("post_rst_t1_x", int'(x_center), 320);
        check_val("post_rst_t1_speed", int'(speed), 0);
        frame();
        check_val("post_rst_t2_x", int'(x_center), 321);
        check_val("post_rst_t2_speed", int'(speed), 1);
        btn_right = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
